// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The master side drives the datapath controls. The slave side returns IR fields and status.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic [1:0] PCsrc;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       Reg_Write;
    logic [1:0] RegDst;
    logic [1:0] memToReg;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [1:0] ALUop;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, func, Zero, mem_ready,
        output PCWrite, PCsrc, IorD, memRead, memWrite, IRWrite, Reg_Write,
               RegDst, memToReg, ALUsrcA, ALUsrcB, ALUop, instr_done, state
    );

    modport slave (
        output opcode, func, Zero, mem_ready,
        input  PCWrite, PCsrc, IorD, memRead, memWrite, IRWrite, Reg_Write,
               RegDst, memToReg, ALUsrcA, ALUsrcB, ALUop, instr_done, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath. It decodes opcode/func and
// drives every mux select and write enable for the current state.
module multicycle_controller (
    input  logic                         clk,
    input  logic                         rst,
    multicycle_controller_if.master      bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        IMMEX  = 4'd8,
        IMMWB  = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t cur;
    logic   op_known;

    always_comb begin
        op_known = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_LW, OP_SW: op_known = 1'b1;
            default:                        op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:  if (bus.mem_ready) cur <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW:     cur <= MEMADR;
                        OP_RTYPE:         cur <= (bus.func == FN_JR) ? JR : RTEX;
                        OP_ADDI, OP_SLTI: cur <= IMMEX;
                        OP_BEQ, OP_BNE:   cur <= BRANCH;
                        OP_J:             cur <= JUMP;
                        OP_JAL:           cur <= JAL;
                        default:          cur <= FETCH;
                    endcase
                end
                MEMADR: cur <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (bus.mem_ready) cur <= MEMWB;
                MEMWB:  cur <= FETCH;
                MEMWR:  if (bus.mem_ready) cur <= FETCH;
                RTEX:   cur <= RTWB;
                RTWB:   cur <= FETCH;
                IMMEX:  cur <= IMMWB;
                IMMWB:  cur <= FETCH;
                BRANCH: cur <= FETCH;
                JUMP:   cur <= FETCH;
                JAL:    cur <= FETCH;
                JR:     cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    assign bus.state = cur;

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.PCsrc      = '0;
        bus.IorD       = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.Reg_Write  = 1'b0;
        bus.RegDst     = '0;
        bus.memToReg   = '0;
        bus.ALUsrcA    = 1'b0;
        bus.ALUsrcB    = '0;
        bus.ALUop      = '0;
        bus.instr_done = 1'b0;
        case (cur)
            FETCH: begin
                bus.memRead = 1'b1;
                bus.ALUsrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            DECODE: begin
                // The branch target is computed here so that BRANCH can load it from ALUOut.
                bus.ALUsrcB    = 2'b11;
                bus.instr_done = ~op_known;
            end
            MEMADR: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUsrcB = 2'b10;
            end
            MEMRD: begin
                bus.memRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.Reg_Write  = 1'b1;
                bus.memToReg   = 2'b01;
                bus.instr_done = 1'b1;
            end
            MEMWR: begin
                bus.memWrite   = 1'b1;
                bus.IorD       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            RTEX: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUop   = 2'b10;
            end
            RTWB: begin
                bus.Reg_Write  = 1'b1;
                bus.RegDst     = 2'b01;
                bus.instr_done = 1'b1;
            end
            IMMEX: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUsrcB = 2'b10;
                bus.ALUop   = (bus.opcode == OP_SLTI) ? 2'b11 : 2'b00;
            end
            IMMWB: begin
                bus.Reg_Write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            BRANCH: begin
                bus.ALUsrcA    = 1'b1;
                bus.ALUop      = 2'b01;
                bus.PCsrc      = 2'b01;
                bus.PCWrite    = (bus.opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
                bus.instr_done = 1'b1;
            end
            JUMP: begin
                bus.PCsrc      = 2'b10;
                bus.PCWrite    = 1'b1;
                bus.instr_done = 1'b1;
            end
            JAL: begin
                bus.PCsrc      = 2'b10;
                bus.PCWrite    = 1'b1;
                bus.Reg_Write  = 1'b1;
                bus.RegDst     = 2'b10;
                bus.memToReg   = 2'b10;
                bus.instr_done = 1'b1;
            end
            JR: begin
                bus.PCsrc      = 2'b11;
                bus.PCWrite    = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset masks every side effect immediately, including one that would occur mid-access.
        if (rst) begin
            bus.PCWrite    = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.Reg_Write  = 1'b0;
            bus.memWrite   = 1'b0;
            bus.memRead    = 1'b0;
            bus.instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each step checks the state and the control
// outputs against values computed by hand.
module tb_multicycle_controller;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.opcode = 6'h00;
        bus.func = 6'h20;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;

        #12;
        chk("rst_state", 8'(bus.state), 8'd0);
        chk("rst_memRead", 8'(bus.memRead), 8'd0);
        chk("rst_IRWrite", 8'(bus.IRWrite), 8'd0);
        chk("rst_PCWrite", 8'(bus.PCWrite), 8'd0);
        rst = 1'b0;
        #1;
        chk("fetch_memRead", 8'(bus.memRead), 8'd1);
        chk("fetch_IRWrite", 8'(bus.IRWrite), 8'd1);
        chk("fetch_ALUsrcB", 8'(bus.ALUsrcB), 8'd1);
        chk("fetch_IorD", 8'(bus.IorD), 8'd0);

        // lw: states 0,1,2,3,4
        bus.opcode = 6'h23;
        cyc(); chk("lw_s1", 8'(bus.state), 8'd1);
        chk("dec_ALUsrcB", 8'(bus.ALUsrcB), 8'd3);
        chk("dec_done", 8'(bus.instr_done), 8'd0);
        cyc(); chk("lw_s2", 8'(bus.state), 8'd2);
        chk("madr_ALUsrcA", 8'(bus.ALUsrcA), 8'd1);
        chk("madr_ALUsrcB", 8'(bus.ALUsrcB), 8'd2);
        cyc(); chk("lw_s3", 8'(bus.state), 8'd3);
        chk("memrd_IorD", 8'(bus.IorD), 8'd1);
        chk("memrd_memRead", 8'(bus.memRead), 8'd1);
        chk("memrd_RegWrite", 8'(bus.Reg_Write), 8'd0);
        cyc(); chk("lw_s4", 8'(bus.state), 8'd4);
        chk("memwb_RegWrite", 8'(bus.Reg_Write), 8'd1);
        chk("memwb_memToReg", 8'(bus.memToReg), 8'd1);
        chk("memwb_RegDst", 8'(bus.RegDst), 8'd0);
        chk("memwb_done", 8'(bus.instr_done), 8'd1);
        cyc(); chk("lw_back", 8'(bus.state), 8'd0);
        chk("fetch_done", 8'(bus.instr_done), 8'd0);

        // beq
        bus.opcode = 6'h04;
        bus.Zero = 1'b1;
        cyc(); cyc(); chk("beq_s", 8'(bus.state), 8'd10);
        chk("beq_z1_PCWrite", 8'(bus.PCWrite), 8'd1);
        chk("beq_PCsrc", 8'(bus.PCsrc), 8'd1);
        chk("beq_ALUop", 8'(bus.ALUop), 8'd1);
        chk("beq_done", 8'(bus.instr_done), 8'd1);
        bus.Zero = 1'b0;
        #1;
        chk("beq_z0_PCWrite", 8'(bus.PCWrite), 8'd0);
        cyc(); chk("beq_back", 8'(bus.state), 8'd0);

        // bne
        bus.opcode = 6'h05;
        bus.Zero = 1'b1;
        cyc(); cyc(); chk("bne_s", 8'(bus.state), 8'd10);
        chk("bne_z1_PCWrite", 8'(bus.PCWrite), 8'd0);
        bus.Zero = 1'b0;
        #1;
        chk("bne_z0_PCWrite", 8'(bus.PCWrite), 8'd1);
        cyc(); chk("bne_back", 8'(bus.state), 8'd0);

        // fetch stall
        bus.mem_ready = 1'b0;
        #1;
        chk("fstall_IRWrite", 8'(bus.IRWrite), 8'd0);
        chk("fstall_PCWrite", 8'(bus.PCWrite), 8'd0);
        chk("fstall_memRead", 8'(bus.memRead), 8'd1);
        cyc(); chk("fstall_state", 8'(bus.state), 8'd0);
        bus.mem_ready = 1'b1;

        // sw with three wait cycles in MEMWR
        bus.opcode = 6'h2b;
        cyc(); cyc(); chk("sw_s2", 8'(bus.state), 8'd2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sw_wait_state", 8'(bus.state), 8'd5);
            chk("sw_wait_memWrite", 8'(bus.memWrite), 8'd1);
            chk("sw_wait_IorD", 8'(bus.IorD), 8'd1);
            chk("sw_wait_done", 8'(bus.instr_done), 8'd0);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("sw_ready_done", 8'(bus.instr_done), 8'd1);
        chk("sw_ready_memWrite", 8'(bus.memWrite), 8'd1);
        cyc(); chk("sw_back", 8'(bus.state), 8'd0);

        // reset asserted while MEMWR is waiting on memory
        cyc(); cyc(); bus.mem_ready = 1'b0;
        cyc(); chk("swr_s5", 8'(bus.state), 8'd5);
        chk("swr_memWrite", 8'(bus.memWrite), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 8'(bus.state), 8'd0);
        chk("arst_memWrite", 8'(bus.memWrite), 8'd0);
        chk("arst_memRead", 8'(bus.memRead), 8'd0);
        chk("arst_IRWrite", 8'(bus.IRWrite), 8'd0);
        chk("arst_done", 8'(bus.instr_done), 8'd0);
        bus.mem_ready = 1'b1;
        cyc();
        chk("arst_hold_state", 8'(bus.state), 8'd0);
        chk("arst_hold_PCWrite", 8'(bus.PCWrite), 8'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rel_memRead", 8'(bus.memRead), 8'd1);
        chk("arst_rel_PCWrite", 8'(bus.PCWrite), 8'd1);

        // jal
        bus.opcode = 6'h03;
        cyc(); cyc(); chk("jal_s", 8'(bus.state), 8'd12);
        chk("jal_RegDst", 8'(bus.RegDst), 8'd2);
        chk("jal_memToReg", 8'(bus.memToReg), 8'd2);
        chk("jal_PCsrc", 8'(bus.PCsrc), 8'd2);
        chk("jal_RegWrite", 8'(bus.Reg_Write), 8'd1);
        chk("jal_PCWrite", 8'(bus.PCWrite), 8'd1);
        cyc(); chk("jal_back", 8'(bus.state), 8'd0);

        // jr
        bus.opcode = 6'h00;
        bus.func = 6'h08;
        cyc(); cyc(); chk("jr_s", 8'(bus.state), 8'd13);
        chk("jr_PCsrc", 8'(bus.PCsrc), 8'd3);
        chk("jr_RegWrite", 8'(bus.Reg_Write), 8'd0);
        chk("jr_PCWrite", 8'(bus.PCWrite), 8'd1);
        cyc();

        // j
        bus.opcode = 6'h02;
        cyc(); cyc(); chk("j_s", 8'(bus.state), 8'd11);
        chk("j_PCsrc", 8'(bus.PCsrc), 8'd2);
        chk("j_RegWrite", 8'(bus.Reg_Write), 8'd0);
        cyc();

        // R-type add
        bus.opcode = 6'h00;
        bus.func = 6'h20;
        cyc(); cyc(); chk("rt_s6", 8'(bus.state), 8'd6);
        chk("rt_ALUop", 8'(bus.ALUop), 8'd2);
        chk("rt_ALUsrcB", 8'(bus.ALUsrcB), 8'd0);
        cyc(); chk("rt_s7", 8'(bus.state), 8'd7);
        chk("rt_RegDst", 8'(bus.RegDst), 8'd1);
        chk("rt_RegWrite", 8'(bus.Reg_Write), 8'd1);
        cyc(); chk("rt_back", 8'(bus.state), 8'd0);

        // addi and slti
        bus.opcode = 6'h08;
        cyc(); cyc(); chk("addi_s8", 8'(bus.state), 8'd8);
        chk("addi_ALUop", 8'(bus.ALUop), 8'd0);
        cyc(); chk("addi_s9", 8'(bus.state), 8'd9);
        chk("addi_RegDst", 8'(bus.RegDst), 8'd0);
        chk("addi_RegWrite", 8'(bus.Reg_Write), 8'd1);
        cyc();
        bus.opcode = 6'h0a;
        cyc(); cyc(); chk("slti_s8", 8'(bus.state), 8'd8);
        chk("slti_ALUop", 8'(bus.ALUop), 8'd3);
        cyc(); cyc(); chk("slti_back", 8'(bus.state), 8'd0);

        // undefined opcode
        bus.opcode = 6'h3f;
        cyc(); chk("undef_s1", 8'(bus.state), 8'd1);
        chk("undef_done", 8'(bus.instr_done), 8'd1);
        chk("undef_RegWrite", 8'(bus.Reg_Write), 8'd0);
        chk("undef_memWrite", 8'(bus.memWrite), 8'd0);
        chk("undef_PCWrite", 8'(bus.PCWrite), 8'd0);
        cyc(); chk("undef_back", 8'(bus.state), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencer for the MIPS datapath. The datapath shares one memory, one ALU and internal registers (IR, MDR, A, B, ALUOut) across several cycles per instruction. The block is a Moore FSM that decodes `opcode`/`func` from the IR and drives every datapath mux select and write enable state by state. It replaces single-cycle decode when the CPU is built in multicycle form and supports R-type, jr, addi, slti, lw, sw, beq, bne, j and jal.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]. The IR holds it stable from DECODE until the next FETCH.
- `func` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag, combinational from the current ALU operation.
- `mem_ready` in 1: memory completes the current access this cycle. Tie to 1 for single-cycle memory.
- `PCWrite` out 1: PC load enable. Includes the branch condition.
- `PCsrc` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 2'b00}, 11 = A (jr).
- `IorD` out 1: memory address. 0 = PC, 1 = ALUOut.
- `memRead` out 1: memory read request.
- `memWrite` out 1: memory write request.
- `IRWrite` out 1: IR load enable.
- `Reg_Write` out 1: register file write enable.
- `RegDst` out 2: write register. 00 = rt, 01 = rd, 10 = $31.
- `memToReg` out 2: write data. 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALUsrcA` out 1: ALU operand A. 0 = PC, 1 = A.
- `ALUsrcB` out 2: ALU operand B. 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUop` out 2: to ALU_controller. 00 = add, 01 = sub, 10 = decode from `func`, 11 = slt.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `state` out 4: current state encoding, for debug and verification.

## Operation
- 4-bit state register. All outputs are decoded combinationally from the state, plus `Zero`/`opcode` where noted. Any output not listed for a state is 0.
- **FETCH (0):** memRead, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=00, PCsrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- **DECODE (1):** ALUsrcA=0, ALUsrcB=11, ALUop=00, which places the branch target in ALUOut. Next state by opcode:
  - lw 0x23 / sw 0x2b → MEMADR
  - 0x00 with func=0x08 → JR; any other func → RTEX
  - addi 0x08 / slti 0x0a → IMMEX
  - beq 0x04 / bne 0x05 → BRANCH
  - j 0x02 → JUMP
  - jal 0x03 → JAL
  - Any other opcode → FETCH, with instr_done=1 in DECODE.
- **MEMADR (2):** ALUsrcA=1, ALUsrcB=10, ALUop=00. Go to MEMRD for lw, MEMWR for sw.
- **MEMRD (3):** memRead, IorD=1. Hold until mem_ready, then go to MEMWB.
- **MEMWB (4):** Reg_Write, RegDst=00, memToReg=01, then FETCH.
- **MEMWR (5):** memWrite, IorD=1. Hold until mem_ready; instr_done=mem_ready. Then FETCH.
- **RTEX (6):** ALUsrcA=1, ALUsrcB=00, ALUop=10, then RTWB.
- **RTWB (7):** Reg_Write, RegDst=01, memToReg=00, then FETCH.
- **IMMEX (8):** ALUsrcA=1, ALUsrcB=10, ALUop=00 for addi or 11 for slti, then IMMWB.
- **IMMWB (9):** Reg_Write, RegDst=00, memToReg=00, then FETCH.
- **BRANCH (10):** ALUsrcA=1, ALUsrcB=00, ALUop=01, PCsrc=01.
  - PCWrite=Zero for beq, ~Zero for bne.
  - Then FETCH.
- **JUMP (11):** PCsrc=10, PCWrite, then FETCH.
- **JAL (12):** PCsrc=10, PCWrite, Reg_Write, RegDst=10, memToReg=10, then FETCH. PC already holds PC+4 at this point, so $31 receives the return address.
- **JR (13):** PCsrc=11, PCWrite, then FETCH.
- instr_done=1 in MEMWB, MEMWR (when mem_ready), RTWB, IMMWB, BRANCH, JUMP, JAL and JR.
- Encodings 14 and 15 are unreachable. If entered, they go to FETCH with all outputs 0.

## Timing
- **Reset:** `rst` forces state=FETCH immediately, without waiting for a clock edge.
  - While rst=1, the following are forced to 0: PCWrite, IRWrite, Reg_Write, memWrite, memRead, instr_done.
  - The first fetch happens on the first rising edge after rst deasserts.
  - Asserting rst mid-instruction abandons that instruction. No partial register or memory write occurs after assertion.
- **Cycle counts with mem_ready=1:**
  - lw: 5
  - sw, R-type, addi, slti: 4
  - beq, bne, j, jal, jr: 3
  - Undefined opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- While waiting on memory, memRead/memWrite and IorD stay stable; PCWrite and IRWrite stay 0.
- **Branch:** `Zero` is sampled combinationally within the BRANCH cycle. The PC update lands on the edge that leaves BRANCH.

## Test plan
- **Reset mid-MEMWR:** pulse rst during MEMWR → state=0 asynchronously, memWrite drops without a clock edge, all enables 0 during reset, FETCH outputs after release.
- **lw sequence (opcode 0x23, mem_ready=1):** states 0,1,2,3,4 → Reg_Write only in state 4 with memToReg=01, RegDst=00; instr_done high one cycle.
- **Branches with Zero=1:** beq → PCWrite=1, PCsrc=01 in state 10; bne → PCWrite=0. Repeat with Zero=0 → the two responses invert.
- **Memory stall:** sw with mem_ready low 3 cycles in MEMWR → memWrite held 3+1 cycles, instr_done only on the ready cycle, 7 cycles total.
- **Jumps:** jal 0x03 → state 12, RegDst=10, memToReg=10, PCsrc=10, Reg_Write=1. jr (opcode 0, func 0x08) → state 13, PCsrc=11, Reg_Write=0.
- **Undefined opcode 0x3f:** FETCH→DECODE→FETCH, no write enable asserted, instr_done pulses in DECODE.
